overture_core_p: RTL and testbench
==================================

OVERTURE_CORE_P -- requirements
Module: overture_core_p

Interface
REQ-001 Parameter DATA_W, default 8, register/datapath width; legal range 8..32.
REQ-002 Parameter PC_W, default 8, program-counter and instruction-address width; legal range 4..DATA_W.
REQ-003 Parameter STACK_DEPTH, default 4, call-stack entries; legal range 1..16.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 imem_addr  out  PC_W  instruction address, equal to PC.
REQ-007 imem_data  in  8  instruction word, combinational read of imem_addr.
REQ-008 in_data  in  DATA_W  input-port data.
REQ-009 in_valid  in  1  in_data is valid.
REQ-010 in_ready  out  1  core consumes in_data this cycle.
REQ-011 out_data  out  DATA_W  registered output-port data.
REQ-012 out_valid  out  1  out_data is pending.
REQ-013 out_ready  in  1  sink accepts out_data.
REQ-014 fault  out  1  sticky stack-fault flag; the core is halted while it is high.
REQ-015 fault_code  out  2  fault cause: 01 = overflow, 10 = underflow, 00 = none.

Function
REQ-016 The core SHALL hold registers R0..R5, each DATA_W bits wide; register index 6 SHALL be the I/O port, and index 7 SHALL be reserved.
REQ-017 The core SHALL decode imem_data[7:6] as follows: 00 = IMM, 01 = CALC, 10 = COPY, 11 = COND.
REQ-018 IMM SHALL load R0 with imem_data[5:0], zero-extended to DATA_W.
REQ-019 CALC SHALL write R3 = R1 op R2, with op = imem_data[2:0]: 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB, 6 XOR, 7 SHL1 (R1<<1).
REQ-020 CALC results SHALL be modulo 2^DATA_W, with no carry or flag state.
REQ-021 COPY SHALL move src = imem_data[5:3] to dst = imem_data[2:0].
REQ-022 COPY with src=7 and dst=7 SHALL be RET; any other COPY using index 7 SHALL be a no-op that advances PC.
REQ-023 COND SHALL evaluate cond = imem_data[2:0] on R3 as signed DATA_W: 0 never, 1 =0, 2 <0, 3 <=0, 4 always, 5 !=0, 6 >=0, 7 >0.
REQ-024 COND true SHALL set PC = R0[PC_W-1:0]; COND false SHALL set PC = PC+1.
REQ-025 COND with imem_data[3]=1 SHALL be CALL: when true, push PC+1 (mod 2^PC_W), then jump; when false, no push.
REQ-026 RET SHALL pop the top of stack into PC.
REQ-027 All non-stalled instructions SHALL complete in one cycle, and PC SHALL wrap 2^PC_W-1 -> 0.
REQ-028 The FSM SHALL have three states: RUN, OUT_WAIT, HALT.
REQ-029 in_ready SHALL be high only in RUN while executing COPY with src=6.
REQ-030 With in_ready high and in_valid low, the core SHALL stall: no writeback, PC held.
REQ-031 COPY to dst=6 in RUN (after its input transfer, if src=6) SHALL register out_data, set out_valid=1, advance PC, and enter OUT_WAIT.
REQ-032 In OUT_WAIT, the core SHALL hold PC and out_data stable; out_valid&&out_ready SHALL clear out_valid and return to RUN on the next cycle.
REQ-033 A push when the stack is full SHALL set fault=1 and fault_code=01, enter HALT, and perform no PC or stack update.
REQ-034 A pop when the stack is empty SHALL set fault=1 and fault_code=10, enter HALT, and perform no PC or stack update.
REQ-035 HALT SHALL be left only via rst; in HALT, in_ready SHALL be 0 and no state SHALL change.
REQ-036 A push SHALL succeed when exactly STACK_DEPTH-1 entries are held, and a pop SHALL succeed when exactly 1 entry is held.

Reset
REQ-037 While rst is high, the core SHALL force PC=0, R0..R5=0, stack pointer=0, state=RUN, out_valid=0, out_data=0, fault=0, fault_code=00.
REQ-038 Reset asserted mid-OUT_WAIT or mid-stall SHALL discard the pending transfer, with out_valid=0 on the cycle after rst.
REQ-039 Reset SHALL take priority over every other event in the same cycle.

Structure
REQ-040 The opcode enum, ALU op codes, condition codes, FSM state type and fault codes SHALL live in a shared package, overture_pkg.
REQ-041 The call stack SHALL be a sub-module, overture_call_stack, with STACK_DEPTH and PC_W parameters and push/pop/full/empty ports.
REQ-042 The register file, ALU, condition unit and FSM SHALL reside in overture_core_p.

Verification
REQ-043 IMM 0x05, COPY 0->1, IMM 0x03, COPY 0->2, CALC ADD -> R3=0x08 after the 5th instruction, with PC=5.
REQ-044 DATA_W=16: R1=0x8000 via SHL1 chain, CALC SUB with R2=1 -> R3=0x7FFF; COND >0 jumps to R0.
REQ-045 Input test: in_valid held 0 for 3 cycles during COPY 6->1 -> PC is unchanged for 3 cycles; in_data=0x2A with in_valid=1 -> R1=0x2A and PC+1.
REQ-046 Output test: COPY 3->6 with out_ready=0 for 4 cycles -> out_valid stays 1, out_data is stable and PC is frozen; out_ready=1 -> RUN resumes the next cycle.
REQ-047 STACK_DEPTH=2: CALL x3 -> the third call sets fault=1 and fault_code=01, PC holds the CALL address; a RET on an empty stack after reset sets fault_code=10.
REQ-048 rst pulsed during OUT_WAIT -> out_valid=0, PC=0, fault=0 on the next cycle.

Source files
------------

// File: rtl/overture_pkg.sv
// Shared types for the overture accumulator-style core: opcodes, ALU ops,
// branch conditions, FSM states and fault causes.
package overture_pkg;

    typedef enum logic [1:0] {
        OP_IMM  = 2'b00,
        OP_CALC = 2'b01,
        OP_COPY = 2'b10,
        OP_COND = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_OR   = 3'd0,
        ALU_NAND = 3'd1,
        ALU_NOR  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_ADD  = 3'd4,
        ALU_SUB  = 3'd5,
        ALU_XOR  = 3'd6,
        ALU_SHL1 = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_NEVER  = 3'd0,
        COND_EQZ    = 3'd1,
        COND_LTZ    = 3'd2,
        COND_LEZ    = 3'd3,
        COND_ALWAYS = 3'd4,
        COND_NEZ    = 3'd5,
        COND_GEZ    = 3'd6,
        COND_GTZ    = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_OUT_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE      = 2'b00,
        FAULT_OVERFLOW  = 2'b01,
        FAULT_UNDERFLOW = 2'b10
    } fault_e;

    localparam logic [2:0] IDX_PORT = 3'd6;
    localparam logic [2:0] IDX_RSVD = 3'd7;

endpackage

// File: rtl/overture_call_stack.sv
// Return-address stack for CALL/RET. Push and pop are ignored when they
// would overflow or underflow; the core checks full/empty before asking.
module overture_call_stack
    import overture_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int PC_W        = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] push_data,
    output logic [PC_W-1:0] top_data,
    output logic            full,
    output logic            empty
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0] sp;
    logic [PC_W-1:0] mem [0:STACK_DEPTH-1];

    assign full     = (sp == SP_W'(STACK_DEPTH));
    assign empty    = (sp == '0);
    assign top_data = mem[IDX_W'(sp - SP_W'(1))];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Entry storage needs no reset: only slots below sp are ever read.
    always_ff @(posedge clk) begin
        if (!rst && push && !full) begin
            mem[IDX_W'(sp)] <= push_data;
        end
    end

endmodule

// File: rtl/overture_core_p.sv
// Single-cycle 8-bit-instruction core: six registers, a memory-mapped I/O
// port at index 6, conditional jumps/calls on R3, and a sticky stack fault.
module overture_core_p
    import overture_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [7:0]        imem_data,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              fault,
    output logic [1:0]        fault_code
);

    logic [DATA_W-1:0] regs [0:5];
    logic [PC_W-1:0]   pc, pc_next, pc_inc, stack_top;
    state_e            state, state_next;
    fault_e            fault_code_q, fault_code_next;

    opcode_e           opcode;
    logic [2:0]        src, dst, reg_waddr;
    logic [DATA_W-1:0] src_val, alu_y, reg_wdata;
    logic              cond_true, is_call, reg_we, out_load, out_clear;
    logic              push, pop, full, empty, fault_set;

    assign opcode     = opcode_e'(imem_data[7:6]);
    assign src        = imem_data[5:3];
    assign dst        = imem_data[2:0];
    assign is_call    = imem_data[3];
    assign pc_inc     = pc + PC_W'(1);
    assign imem_addr  = pc;
    assign fault_code = fault_code_q;

    always_comb begin
        if (src == IDX_PORT)      src_val = in_data;
        else if (src == IDX_RSVD) src_val = '0;
        else                      src_val = regs[src];
    end

    always_comb begin
        case (alu_op_e'(imem_data[2:0]))
            ALU_OR:   alu_y = regs[1] | regs[2];
            ALU_NAND: alu_y = ~(regs[1] & regs[2]);
            ALU_NOR:  alu_y = ~(regs[1] | regs[2]);
            ALU_AND:  alu_y = regs[1] & regs[2];
            ALU_ADD:  alu_y = regs[1] + regs[2];
            ALU_SUB:  alu_y = regs[1] - regs[2];
            ALU_XOR:  alu_y = regs[1] ^ regs[2];
            default:  alu_y = regs[1] << 1;
        endcase
    end

    // R3 is compared as a signed value: sign bit gives <0, all-zero gives =0.
    always_comb begin
        case (cond_e'(imem_data[2:0]))
            COND_NEVER:  cond_true = 1'b0;
            COND_EQZ:    cond_true = (regs[3] == '0);
            COND_LTZ:    cond_true = regs[3][DATA_W-1];
            COND_LEZ:    cond_true = regs[3][DATA_W-1] || (regs[3] == '0);
            COND_ALWAYS: cond_true = 1'b1;
            COND_NEZ:    cond_true = (regs[3] != '0);
            COND_GEZ:    cond_true = !regs[3][DATA_W-1];
            default:     cond_true = !regs[3][DATA_W-1] && (regs[3] != '0);
        endcase
    end

    always_comb begin
        state_next      = state;
        pc_next         = pc;
        reg_we          = 1'b0;
        reg_waddr       = dst;
        reg_wdata       = src_val;
        out_load        = 1'b0;
        out_clear       = 1'b0;
        push            = 1'b0;
        pop             = 1'b0;
        fault_set       = 1'b0;
        fault_code_next = FAULT_NONE;
        in_ready        = 1'b0;
        case (state)
            ST_RUN: begin
                case (opcode)
                    OP_IMM: begin
                        reg_we    = 1'b1;
                        reg_waddr = 3'd0;
                        reg_wdata = DATA_W'(imem_data[5:0]);
                        pc_next   = pc_inc;
                    end
                    OP_CALC: begin
                        reg_we    = 1'b1;
                        reg_waddr = 3'd3;
                        reg_wdata = alu_y;
                        pc_next   = pc_inc;
                    end
                    OP_COPY: begin
                        if (src == IDX_RSVD && dst == IDX_RSVD) begin
                            if (empty) begin
                                fault_set       = 1'b1;
                                fault_code_next = FAULT_UNDERFLOW;
                                state_next      = ST_HALT;
                            end else begin
                                pop     = 1'b1;
                                pc_next = stack_top;
                            end
                        end else if (src == IDX_RSVD || dst == IDX_RSVD) begin
                            pc_next = pc_inc;
                        end else begin
                            in_ready = (src == IDX_PORT);
                            // Missing input data stalls with PC and registers held.
                            if (src == IDX_PORT && !in_valid) begin
                                pc_next = pc;
                            end else if (dst == IDX_PORT) begin
                                out_load   = 1'b1;
                                pc_next    = pc_inc;
                                state_next = ST_OUT_WAIT;
                            end else begin
                                reg_we  = 1'b1;
                                pc_next = pc_inc;
                            end
                        end
                    end
                    default: begin
                        if (!cond_true) begin
                            pc_next = pc_inc;
                        end else if (is_call && full) begin
                            fault_set       = 1'b1;
                            fault_code_next = FAULT_OVERFLOW;
                            state_next      = ST_HALT;
                        end else begin
                            push    = is_call;
                            pc_next = regs[0][PC_W-1:0];
                        end
                    end
                endcase
            end
            ST_OUT_WAIT: begin
                if (out_ready) begin
                    out_clear  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= '0;
            state        <= ST_RUN;
            out_valid    <= 1'b0;
            out_data     <= '0;
            fault        <= 1'b0;
            fault_code_q <= FAULT_NONE;
            for (int i = 0; i < 6; i++) regs[i] <= '0;
        end else begin
            pc    <= pc_next;
            state <= state_next;
            for (int i = 0; i < 6; i++) begin
                if (reg_we && reg_waddr == 3'(i)) regs[i] <= reg_wdata;
            end
            if (out_load) begin
                out_data  <= src_val;
                out_valid <= 1'b1;
            end else if (out_clear) begin
                out_valid <= 1'b0;
            end
            if (fault_set) begin
                fault        <= 1'b1;
                fault_code_q <= fault_code_next;
            end
        end
    end

    overture_call_stack #(
        .STACK_DEPTH (STACK_DEPTH),
        .PC_W        (PC_W)
    ) u_call_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stack_top),
        .full      (full),
        .empty     (empty)
    );

endmodule

// File: tb/tb_overture_core_p.sv
// Directed bench for overture_core_p at DATA_W=16, PC_W=8, STACK_DEPTH=2,
// with a bench-owned instruction ROM and hand-computed expectations.
module tb_overture_core_p;

    localparam int DATA_W = 16;
    localparam int PC_W   = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [PC_W-1:0]   imem_addr;
    logic [7:0]        imem_data;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              fault;
    logic [1:0]        fault_code;

    logic [7:0] imem [0:255];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;
    assign imem_data = imem[imem_addr];

    overture_core_p #(.DATA_W(DATA_W), .PC_W(PC_W), .STACK_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fault      (fault),
        .fault_code (fault_code)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    task automatic clearImem();
        for (int i = 0; i < 256; i++) imem[i] = 8'hC0;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        applyStimulus(2);
        rst = 1'b0;
    endtask

    task automatic waitOutput(input string tag, input logic [DATA_W-1:0] expected);
        int n = 0;
        do begin
            applyStimulus(1);
            n++;
        end while (!out_valid && n < 200);
        if (!out_valid) checkOutput({tag, "_timeout"}, 32'(out_valid), 32'd1);
        else            checkOutput(tag, 32'(out_data), 32'(expected));
    endtask

    // Conditional jump on R3 = r1 - r2; mask bit c says whether cond c is taken.
    task automatic runCond(input string tag, input logic [5:0] r1, input logic [5:0] r2, input logic [7:0] mask);
        for (int c = 0; c < 8; c++) begin
            clearImem();
            imem[0] = {2'b00, r1};
            imem[1] = 8'h81;
            imem[2] = {2'b00, r2};
            imem[3] = 8'h82;
            imem[4] = 8'h45;
            imem[5] = 8'h20;
            imem[6] = 8'hC0 | 8'(c);
            applyReset();
            applyStimulus(7);
            checkOutput($sformatf("%s_c%0d", tag, c), 32'(imem_addr), mask[c] ? 32'h20 : 32'h07);
        end
    endtask

    logic [15:0] alu_exp [0:7];

    initial begin
        alu_exp = '{16'h0007, 16'hFFFE, 16'hFFF8, 16'h0001,
                    16'h0008, 16'h0002, 16'h0006, 16'h000A};
        rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;

        // Basic program, output back-pressure and reset during OUT_WAIT.
        clearImem();
        imem[0] = 8'h05; imem[1] = 8'h81; imem[2] = 8'h03; imem[3] = 8'h82;
        imem[4] = 8'h44; imem[5] = 8'h9E; imem[6] = 8'h01; imem[7] = 8'h9E;
        rst = 1'b1;
        applyStimulus(2);
        checkOutput("rst_pc", 32'(imem_addr), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_fault_code", 32'(fault_code), 32'd0);
        rst = 1'b0;
        applyStimulus(5);
        checkOutput("add_pc5", 32'(imem_addr), 32'd5);
        applyStimulus(1);
        checkOutput("out_valid_set", 32'(out_valid), 32'd1);
        checkOutput("out_data_add", 32'(out_data), 32'h8);
        checkOutput("out_pc", 32'(imem_addr), 32'd6);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("wait%0d_valid", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("wait%0d_data", i), 32'(out_data), 32'h8);
            checkOutput($sformatf("wait%0d_pc", i), 32'(imem_addr), 32'd6);
        end
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("handshake_valid", 32'(out_valid), 32'd0);
        checkOutput("handshake_pc", 32'(imem_addr), 32'd6);
        out_ready = 1'b0;
        applyStimulus(1);
        checkOutput("resume_pc", 32'(imem_addr), 32'd7);
        applyStimulus(1);
        checkOutput("second_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midwait_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("midwait_rst_pc", 32'(imem_addr), 32'd0);
        checkOutput("midwait_rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        // Every ALU operation on R1=5, R2=3.
        clearImem();
        imem[0] = 8'h05; imem[1] = 8'h81; imem[2] = 8'h03; imem[3] = 8'h82;
        for (int k = 0; k < 8; k++) begin
            imem[4 + 2*k] = 8'h40 | 8'(k);
            imem[5 + 2*k] = 8'h9E;
        end
        out_ready = 1'b1;
        applyReset();
        for (int k = 0; k < 8; k++) waitOutput($sformatf("alu_op%0d", k), alu_exp[k]);

        // SHL1 chain to 0x8000, subtract 1, then conditional jumps.
        clearImem();
        imem[0] = 8'h01; imem[1] = 8'h81;
        for (int k = 0; k < 15; k++) begin
            imem[2 + 2*k] = 8'h47;
            imem[3 + 2*k] = 8'h99;
        end
        imem[32] = 8'h8E; imem[33] = 8'h01; imem[34] = 8'h82; imem[35] = 8'h45;
        imem[36] = 8'h9E; imem[37] = 8'h30; imem[38] = 8'hC1; imem[39] = 8'hC7;
        applyReset();
        waitOutput("shl_chain", 16'h8000);
        waitOutput("sub_wrap", 16'h7FFF);
        checkOutput("sub_pc", 32'(imem_addr), 32'd37);
        applyStimulus(3);
        checkOutput("cond_eqz_false", 32'(imem_addr), 32'd39);
        applyStimulus(1);
        checkOutput("cond_gtz_jump", 32'(imem_addr), 32'h30);

        runCond("zero", 6'd5, 6'd5, 8'h5A);
        runCond("pos", 6'd5, 6'd3, 8'hF0);
        runCond("neg", 6'd3, 6'd5, 8'h3C);

        // Input stall then transfer, echoed to the output port.
        clearImem();
        imem[0] = 8'hB1; imem[1] = 8'h8E;
        in_valid = 1'b0;
        applyReset();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd1);
            applyStimulus(1);
            checkOutput($sformatf("stall%0d_pc", i), 32'(imem_addr), 32'd0);
        end
        in_data = 16'h002A; in_valid = 1'b1;
        applyStimulus(1);
        checkOutput("in_pc", 32'(imem_addr), 32'd1);
        in_valid = 1'b0;
        applyStimulus(1);
        checkOutput("in_echo", 32'(out_data), 32'h2A);

        // Stack overflow with STACK_DEPTH=2.
        clearImem();
        imem[0] = 8'h04; imem[1] = 8'hCC; imem[4] = 8'hCC;
        applyReset();
        applyStimulus(3);
        checkOutput("call2_pc", 32'(imem_addr), 32'd4);
        checkOutput("call2_fault", 32'(fault), 32'd0);
        applyStimulus(1);
        checkOutput("ovf_fault", 32'(fault), 32'd1);
        checkOutput("ovf_code", 32'(fault_code), 32'd1);
        checkOutput("ovf_pc", 32'(imem_addr), 32'd4);
        applyStimulus(2);
        checkOutput("halt_pc", 32'(imem_addr), 32'd4);
        checkOutput("halt_fault", 32'(fault), 32'd1);
        applyReset();
        checkOutput("clear_fault", 32'(fault), 32'd0);
        checkOutput("clear_code", 32'(fault_code), 32'd0);

        // Call then return, then a return on the now-empty stack.
        clearImem();
        imem[0] = 8'h08; imem[1] = 8'hCC; imem[8] = 8'hBF; imem[2] = 8'hBF; imem[3] = 8'hB1;
        applyReset();
        applyStimulus(2);
        checkOutput("call_pc", 32'(imem_addr), 32'd8);
        applyStimulus(1);
        checkOutput("ret_pc", 32'(imem_addr), 32'd2);
        applyStimulus(1);
        checkOutput("unf_code", 32'(fault_code), 32'd2);
        checkOutput("unf_pc", 32'(imem_addr), 32'd2);
        checkOutput("halt_in_ready", 32'(in_ready), 32'd0);

        // RET straight after reset.
        clearImem();
        imem[0] = 8'hBF;
        applyReset();
        applyStimulus(1);
        checkOutput("rst_ret_fault", 32'(fault), 32'd1);
        checkOutput("rst_ret_code", 32'(fault_code), 32'd2);
        checkOutput("rst_ret_pc", 32'(imem_addr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
